cache_stats_counter: RTL and testbench

Clocked statistics engine for the L2 cache model. It replaces ad-hoc testbench hit/miss/read/write integers with per-channel saturating counters for NUM_CHANNELS caches or ports. A snapshot request copies all live counters into a shadow bank in one cycle, optionally clears them, and streams the shadow bank out over a valid/ready port. The bench's "PS" (print stats) handler drives it.

---
 rtl/cache_stats_pkg.sv | 18 +
 rtl/stats_sat_counter.sv | 31 +++
 rtl/cache_stats_counter.sv | 187 ++++++++++++++++++
 tb/tb_cache_stats_counter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared types for the cache statistics engine: event kinds and FSM states.
package cache_stats_pkg;

  localparam int NUM_KINDS = 4;

  typedef enum logic [1:0] {
    KIND_HIT,
    KIND_MISS,
    KIND_READ,
    KIND_WRITE
  } stat_kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } stats_state_e;

endpackage

// File: rtl/stats_sat_counter.sv
// Saturating event counter with a sticky flag that sets once the count is pinned at max.
module stats_sat_counter
  import cache_stats_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr_load,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 sat
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // clr_load restarts from zero but still keeps the event of the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr_load) begin
      count <= CNT_WIDTH'(inc);
      sat   <= 1'b0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
      if (count == CNT_MAX - 1'b1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_stats_counter.sv
// Per-channel hit/miss/read/write counters with a snapshot bank streamed over valid/ready.
// Optional aggregate words after the per-channel words: define CACHE_STATS_TOTALS_EN.
//
// state     | meaning
// ST_IDLE   | counting; snap_req captures live counters into the shadow bank
// ST_STREAM | shadow bank words presented on rd_*, snap_req is dropped
module cache_stats_counter
  import cache_stats_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int CNT_WIDTH    = 32,
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CHANNELS-1:0]       ev_hit,
  input  logic [NUM_CHANNELS-1:0]       ev_miss,
  input  logic [NUM_CHANNELS-1:0]       ev_read,
  input  logic [NUM_CHANNELS-1:0]       ev_write,
  input  logic                          snap_req,
  input  logic                          snap_clear,
  output logic                          snap_ack,
  output logic                          snap_drop,
  output logic                          busy,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [CNT_WIDTH-1:0]          rd_data,
  output logic [CH_W-1:0]               rd_chan,
  output logic [1:0]                    rd_kind,
  output logic                          rd_last,
  output logic [NUM_CHANNELS*4-1:0]     sat_flags
`ifdef CACHE_STATS_TOTALS_EN
  ,
  output logic                          totals_word
`endif
);

  localparam int NUM_CNT = NUM_CHANNELS * NUM_KINDS;
`ifdef CACHE_STATS_TOTALS_EN
  localparam int NUM_WORDS = NUM_CNT + NUM_KINDS;
`else
  localparam int NUM_WORDS = NUM_CNT;
`endif
  localparam int PTR_W     = $clog2(NUM_WORDS);
  localparam int CNT_IDX_W = $clog2(NUM_CNT);

  stats_state_e           state_q, state_d;
  logic                   capture, accept, drop, last_word;
  logic [NUM_CNT-1:0]     ev_bus;
  logic [CNT_WIDTH-1:0]   live   [NUM_CNT];
  logic [CNT_WIDTH-1:0]   shadow [NUM_CNT];
  logic [PTR_W-1:0]       ptr, ptr_nxt;
  logic [CNT_WIDTH-1:0]   nxt_data;
  logic [CH_W-1:0]        nxt_chan;
  stat_kind_e             nxt_kind;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ev
    assign ev_bus[c*NUM_KINDS + 0] = ev_hit[c];
    assign ev_bus[c*NUM_KINDS + 1] = ev_miss[c];
    assign ev_bus[c*NUM_KINDS + 2] = ev_read[c];
    assign ev_bus[c*NUM_KINDS + 3] = ev_write[c];
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    stats_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (ev_bus[i]),
      .clr_load (capture && snap_clear),
      .count    (live[i]),
      .sat      (sat_flags[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (snap_req) state_d = ST_STREAM;
      ST_STREAM: if (rd_ready && last_word) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_STREAM);
    rd_valid = busy;
    capture  = (state_q == ST_IDLE) && snap_req;
    accept   = busy && rd_ready;
    drop     = busy && snap_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ack  <= 1'b0;
      snap_drop <= 1'b0;
    end else begin
      snap_ack  <= capture;
      snap_drop <= drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
    end
  end

`ifdef CACHE_STATS_TOTALS_EN
  localparam int SUM_W = CNT_WIDTH + CH_W;
  logic [SUM_W-1:0]     tot_sum [NUM_KINDS];
  logic [CNT_WIDTH-1:0] tot_sat [NUM_KINDS];
  logic                 nxt_tot;

  always_comb begin
    for (int k = 0; k < NUM_KINDS; k++) begin
      tot_sum[k] = '0;
      for (int c = 0; c < NUM_CHANNELS; c++)
        tot_sum[k] = tot_sum[k] + SUM_W'(shadow[c*NUM_KINDS + k]);
      tot_sat[k] = (|tot_sum[k][SUM_W-1:CNT_WIDTH]) ? '1 : tot_sum[k][CNT_WIDTH-1:0];
    end
  end
`endif

  assign ptr_nxt   = ptr + 1'b1;
  assign last_word = (ptr == PTR_W'(NUM_WORDS - 1));

  always_comb begin
    nxt_kind = stat_kind_e'(ptr_nxt[1:0]);
    nxt_chan = '0;
    nxt_data = '0;
`ifdef CACHE_STATS_TOTALS_EN
    nxt_tot  = 1'b0;
    if (int'(ptr_nxt) >= NUM_CNT) begin
      nxt_tot  = 1'b1;
      nxt_data = tot_sat[ptr_nxt[1:0]];
    end else
`endif
    begin
      nxt_chan = CH_W'(ptr_nxt >> 2);
      nxt_data = shadow[ptr_nxt[CNT_IDX_W-1:0]];
    end
  end

  // word 0 is loaded from the live counters on the capture edge, in step with the shadow bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      rd_data <= '0;
      rd_chan <= '0;
      rd_kind <= KIND_HIT;
      rd_last <= 1'b0;
`ifdef CACHE_STATS_TOTALS_EN
      totals_word <= 1'b0;
`endif
    end else if (capture) begin
      ptr     <= '0;
      rd_data <= live[0];
      rd_chan <= '0;
      rd_kind <= KIND_HIT;
      rd_last <= 1'b0;
`ifdef CACHE_STATS_TOTALS_EN
      totals_word <= 1'b0;
`endif
    end else if (accept) begin
      if (last_word) begin
        rd_last <= 1'b0;
      end else begin
        ptr     <= ptr_nxt;
        rd_data <= nxt_data;
        rd_chan <= nxt_chan;
        rd_kind <= nxt_kind;
        rd_last <= (ptr_nxt == PTR_W'(NUM_WORDS - 1));
`ifdef CACHE_STATS_TOTALS_EN
        totals_word <= nxt_tot;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cache_stats_counter.sv
// Directed bench for cache_stats_counter (4 channels, 4-bit counters to reach saturation quickly).
module tb_cache_stats_counter;

  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int NCNT = NCH * 4;
`ifdef CACHE_STATS_TOTALS_EN
  localparam int NW = NCNT + 4;
`else
  localparam int NW = NCNT;
`endif

  logic            clk, rst_n;
  logic [NCH-1:0]  ev_hit, ev_miss, ev_read, ev_write;
  logic            snap_req, snap_clear, snap_ack, snap_drop, busy;
  logic            rd_valid, rd_ready, rd_last;
  logic [CW-1:0]   rd_data;
  logic [1:0]      rd_chan;
  logic [1:0]      rd_kind;
  logic [NCNT-1:0] sat_flags;
`ifdef CACHE_STATS_TOTALS_EN
  logic            totals_word;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [CW-1:0] exp_data [NW];

  cache_stats_counter #(.NUM_CHANNELS(NCH), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_hit     (ev_hit),
    .ev_miss    (ev_miss),
    .ev_read    (ev_read),
    .ev_write   (ev_write),
    .snap_req   (snap_req),
    .snap_clear (snap_clear),
    .snap_ack   (snap_ack),
    .snap_drop  (snap_drop),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_chan    (rd_chan),
    .rd_kind    (rd_kind),
    .rd_last    (rd_last),
    .sat_flags  (sat_flags)
`ifdef CACHE_STATS_TOTALS_EN
    ,
    .totals_word(totals_word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < NW; i++) exp_data[i] = '0;
  endtask

  task automatic fill_totals();
`ifdef CACHE_STATS_TOTALS_EN
    for (int k = 0; k < 4; k++) begin
      int s = 0;
      for (int c = 0; c < NCH; c++) s += int'(exp_data[c*4 + k]);
      exp_data[NCNT + k] = (s > 15) ? 4'd15 : CW'(s);
    end
`endif
  endtask

  task automatic do_snap(input bit clr);
    snap_req   = 1'b1;
    snap_clear = clr;
    tick();
    snap_req   = 1'b0;
    snap_clear = 1'b0;
    chk("snap_ack", snap_ack, 1);
    chk("busy_after_capture", busy, 1);
  endtask

  task automatic run_stream(input bit bp, input bit drop_en);
    int idx = 0;
    int cyc = 0;
    int acc = 0;
    bit req_prev = 1'b0;
    logic [3:0] pat = 4'b1001;
    fill_totals();
    while (idx < NW && cyc < 400) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, exp_data[idx]);
      chk("rd_chan", rd_chan, (idx < NCNT) ? idx / 4 : 0);
      chk("rd_kind", rd_kind, idx % 4);
      chk("rd_last", rd_last, (idx == NW - 1) ? 1 : 0);
      chk("snap_drop", snap_drop, req_prev);
      chk("snap_ack_once", snap_ack, (cyc == 0) ? 1 : 0);
`ifdef CACHE_STATS_TOTALS_EN
      chk("totals_word", totals_word, (idx >= NCNT) ? 1 : 0);
`endif
      rd_ready = bp ? pat[cyc % 4] : 1'b1;
      snap_req = drop_en && (cyc == 3);
      req_prev = snap_req;
      tick();
      if (rd_ready) begin
        idx++;
        acc++;
      end
      cyc++;
    end
    snap_req = 1'b0;
    rd_ready = 1'b0;
    chk("accepted", acc, NW);
    chk("rd_valid_end", rd_valid, 0);
    chk("busy_end", busy, 0);
    chk("rd_last_end", rd_last, 0);
    chk("snap_drop_end", snap_drop, req_prev);
  endtask

  initial begin
    rst_n = 1'b0; ev_hit = '0; ev_miss = '0; ev_read = '0; ev_write = '0;
    snap_req = 1'b0; snap_clear = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_snap_ack", snap_ack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sat_flags", sat_flags, 0);
    rst_n = 1'b1;
    tick();

    // ch0 hit x10, ch2 miss x3
    for (int i = 0; i < 10; i++) begin
      ev_hit  = 4'b0001;
      ev_miss = (i < 3) ? 4'b0100 : 4'b0000;
      tick();
    end
    ev_hit = '0; ev_miss = '0;
    do_snap(1'b0);
    clr_exp();
    exp_data[0] = 4'd10;
    exp_data[9] = 4'd3;
    run_stream(1'b0, 1'b0);

    // ch1 read saturates; live counters kept from the non-clearing capture
    ev_read = 4'b0010;
    repeat (20) tick();
    ev_read = '0;
    chk("sat_flag_set", sat_flags, 32'h0040);
    do_snap(1'b1);
    chk("sat_flags_cleared", sat_flags, 0);
    exp_data[6] = 4'd15;
    run_stream(1'b1, 1'b0);

    // clearing capture with a same-cycle ch0 write; snap_req mid-stream
    ev_hit = 4'b1000;
    repeat (2) tick();
    ev_hit   = '0;
    ev_write = 4'b0001;
    do_snap(1'b1);
    ev_write = '0;
    clr_exp();
    exp_data[12] = 4'd2;
    run_stream(1'b0, 1'b1);

    ev_write = 4'b0001;
    repeat (2) tick();
    ev_write = '0;
    do_snap(1'b0);
    clr_exp();
    exp_data[3] = 4'd3;
    run_stream(1'b0, 1'b0);

    // hits 1,2,3,4 across channels plus all four kinds on ch1 in one cycle
    ev_hit = 4'b1111; tick();
    ev_hit = 4'b1110; tick();
    ev_hit = 4'b1100; tick();
    ev_hit = 4'b1000; tick();
    ev_hit = 4'b0010; ev_miss = 4'b0010; ev_read = 4'b0010; ev_write = 4'b0010; tick();
    ev_hit = '0; ev_miss = '0; ev_read = '0; ev_write = '0;
    do_snap(1'b1);
    clr_exp();
    exp_data[0]  = 4'd1;
    exp_data[3]  = 4'd3;
    exp_data[4]  = 4'd3;
    exp_data[5]  = 4'd1;
    exp_data[6]  = 4'd1;
    exp_data[7]  = 4'd1;
    exp_data[8]  = 4'd3;
    exp_data[12] = 4'd4;
    run_stream(1'b1, 1'b0);

    // reset in the middle of a stream
    do_snap(1'b0);
    rd_ready = 1'b1;
    repeat (3) tick();
    chk("mid_stream_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_last", rd_last, 0);
    chk("abort_rd_data", rd_data, 0);
    rd_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_ack", snap_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
